// File: rtl/rst_sequencer_pkg.sv
// Shared types and default constants for the staged reset sequencer.
package rst_sequencer_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABILIZE = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } seq_state_e;

   localparam int unsigned DefNumStages    = 3;
   localparam int unsigned DefSyncStages   = 2;
   localparam int unsigned DefStableCycles = 1024;
   localparam int unsigned DefStageGap     = 16;

   // Width of the shared counter: it must hold values up to max(a, b) - 1.
   function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/rst_sequencer_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL lock into clk_i.
module rst_sequencer_sync
   import rst_sequencer_pkg::*;
#(
   parameter int unsigned SyncStages = DefSyncStages
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [SyncStages-1:0] sync_q;

   // Shift the raw input through the flop chain; reset forces "not locked".
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour, giving a true shift chain.
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SyncStages-2:0], d_i};
      end
   end

   assign q_o = sync_q[SyncStages-1];

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: waits for a stable PLL lock, then releases
// NumStages active-low resets one after another, StageGap cycles apart.
// Optional feature macro: RST_SEQ_LOCK_LOST_CNT_EN adds lock_lost_cnt_o,
// an 8-bit saturating count of lock losses seen while running.
module rst_sequencer
   import rst_sequencer_pkg::*;
#(
   parameter int unsigned NumStages    = DefNumStages,
   parameter int unsigned SyncStages   = DefSyncStages,
   parameter int unsigned StableCycles = DefStableCycles,
   parameter int unsigned StageGap     = DefStageGap
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 locked_i,
   input  logic                 sw_rst_req_i,
   output logic [NumStages-1:0] rst_stage_no,
   output logic                 rst_done_o,
   output logic                 lock_lost_o
`ifdef RST_SEQ_LOCK_LOST_CNT_EN
   ,
   output logic [7:0]           lock_lost_cnt_o
`endif
);

   localparam int unsigned CntW = cnt_width(StableCycles, StageGap);
   localparam logic [CntW-1:0] StableLast = CntW'(StableCycles - 1);
   localparam logic [CntW-1:0] GapLast    = CntW'(StageGap - 1);

   seq_state_e           state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [NumStages-1:0] stage_q, stage_d;
   logic                 done_q, done_d;
   logic                 lost_q, lost_d;
   logic                 lock_s;
   logic [NumStages:0]   stage_ext;
   logic [NumStages-1:0] stage_shift;

   rst_sequencer_sync #(
      .SyncStages(SyncStages)
   ) u_sync (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (locked_i),
      .q_o   (lock_s)
   );

   // Next release pattern: shift one more '1' in from bit 0, so the released
   // set is always a contiguous run starting at bit 0 (monotonic release).
   assign stage_ext   = {stage_q, 1'b1};
   assign stage_shift = stage_ext[NumStages-1:0];

   // Next-state and next-output logic of the sequencing FSM.
   always_comb begin
      // NOTE: every variable gets a default before the case, so paths that do
      // not assign it hold their value instead of inferring a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      done_d  = done_q;
      lost_d  = lost_q;
      unique case (state_q)
         WAIT_LOCK: begin
            stage_d = '0;
            done_d  = 1'b0;
            if (lock_s) begin
               state_d = STABILIZE;
               cnt_d   = '0;
            end
         end
         STABILIZE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               stage_d = '0;
               done_d  = 1'b0;
            end else if (cnt_q == StableLast) begin
               cnt_d   = '0;
               stage_d = NumStages'(1);
               if (NumStages == 1) begin
                  state_d = RUN;
                  done_d  = 1'b1;
               end else begin
                  state_d = RELEASE;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         RELEASE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               stage_d = '0;
               done_d  = 1'b0;
            end else if (cnt_q == GapLast) begin
               cnt_d   = '0;
               stage_d = stage_shift;
               if (stage_shift[NumStages-1]) begin
                  state_d = RUN;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         RUN: begin
            // Lock loss has priority over a software request.
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               stage_d = '0;
               done_d  = 1'b0;
               lost_d  = 1'b1;
            end else if (sw_rst_req_i) begin
               state_d = STABILIZE;
               cnt_d   = '0;
               stage_d = '0;
               done_d  = 1'b0;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            stage_d = '0;
            done_d  = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         stage_q <= '0;
         done_q  <= 1'b0;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         done_q  <= done_d;
         lost_q  <= lost_d;
      end
   end

   assign rst_stage_no = stage_q;
   assign rst_done_o   = done_q;
   assign lock_lost_o  = lost_q;

`ifdef RST_SEQ_LOCK_LOST_CNT_EN
   logic [7:0] lost_cnt_q;

   // Saturating count of lock losses observed while in RUN.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lost_cnt_q <= '0;
      end else if ((state_q == RUN) && !lock_s && (lost_cnt_q != 8'hFF)) begin
         lost_cnt_q <= lost_cnt_q + 8'd1;
      end
   end

   assign lock_lost_cnt_o = lost_cnt_q;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: directed bring-up, glitch, lock
// loss, software reset, simultaneous events and reset-in-release, followed by
// randomized lock/sw/reset traffic checked cycle by cycle against a model.
module tb_rst_sequencer;

   localparam int NS = 3;
   localparam int SS = 2;
   localparam int SC = 8;
   localparam int SG = 4;
   localparam int DONE_AGE = SC + (NS - 1) * SG;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          locked;
   logic          sw;
   logic [NS-1:0] stage;
   logic          done;
   logic          lost;
`ifdef RST_SEQ_LOCK_LOST_CNT_EN
   logic [7:0]    lost_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: the sequencing "age" is the number of edges since the
   // counter was last cleared on entry to stabilization (-1 while waiting).
   // Stage k is released once age reaches SC + k*SG.
   logic [SS-1:0] m_sync;
   int            m_age;
   bit            m_lost;
   int            m_cnt;

   int rise [NS];
   int done_rise;

   rst_sequencer #(
      .NumStages   (NS),
      .SyncStages  (SS),
      .StableCycles(SC),
      .StageGap    (SG)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .locked_i    (locked),
      .sw_rst_req_i(sw),
      .rst_stage_no(stage),
      .rst_done_o  (done),
      .lock_lost_o (lost)
`ifdef RST_SEQ_LOCK_LOST_CNT_EN
      ,
      .lock_lost_cnt_o(lost_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [NS-1:0] exp_stage(int age);
      logic [NS-1:0] v;
      for (int k = 0; k < NS; k++) v[k] = (age >= SC + k * SG);
      return v;
   endfunction

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic model_edge();
      bit lock_s_m;
      bit in_run;
      lock_s_m = m_sync[SS-1];
      in_run   = (m_age >= DONE_AGE);
      if (!rst_n) begin
         m_age  = -1;
         m_lost = 1'b0;
         m_cnt  = 0;
         m_sync = '0;
      end else begin
         if (m_age >= 0 && !lock_s_m) begin
            if (in_run) begin
               m_lost = 1'b1;
               if (m_cnt < 255) m_cnt++;
            end
            m_age = -1;
         end else if (in_run && sw) begin
            m_age = 0;
         end else if (m_age < 0) begin
            if (lock_s_m) m_age = 0;
         end else if (m_age < DONE_AGE) begin
            m_age++;
         end
         m_sync = {m_sync[SS-2:0], locked};
      end
   endtask

   task automatic compare_all(input string tag);
      logic mono;
      mono = 1'b1;
      for (int k = 1; k < NS; k++) if (stage[k] && !stage[k-1]) mono = 1'b0;
      check({tag, ".stage"}, 32'(stage), 32'(exp_stage(m_age)));
      check({tag, ".done"},  32'(done),  32'(m_age >= DONE_AGE));
      check({tag, ".lost"},  32'(lost),  32'(m_lost));
      check({tag, ".mono"},  32'(mono),  32'd1);
`ifdef RST_SEQ_LOCK_LOST_CNT_EN
      check({tag, ".lcnt"},  32'(lost_cnt), 32'(m_cnt));
`endif
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   // Run n edges and record the edge index (plus base) at which each stage
   // and the done flag first rose.
   task automatic measure(input int n, input int base, input string tag);
      for (int k = 0; k < NS; k++) rise[k] = -1;
      done_rise = -1;
      for (int e = 0; e < n; e++) begin
         tick(tag);
         for (int k = 0; k < NS; k++) if (rise[k] < 0 && stage[k] === 1'b1) rise[k] = e + base;
         if (done_rise < 0 && done === 1'b1) done_rise = e + base;
      end
   endtask

   task automatic check_rises(input string tag, input int r0);
      for (int k = 0; k < NS; k++) check($sformatf("%s.rise%0d", tag, k), 32'(rise[k]), 32'(r0 + k * SG));
      check({tag, ".done_rise"}, 32'(done_rise), 32'(r0 + (NS - 1) * SG));
   endtask

   initial begin
      int low_left;
      rst_n  = 1'b0;
      locked = 1'b0;
      sw     = 1'b0;
      m_sync = '0;
      m_age  = -1;
      m_lost = 1'b0;
      m_cnt  = 0;

      // Reset state
      tick("rst");
      tick("rst");
      check("rst.stage_zero", 32'(stage), 32'd0);
      check("rst.done_zero",  32'(done),  32'd0);
      check("rst.lost_zero",  32'(lost),  32'd0);
      rst_n = 1'b1;
      tick("idle");
      tick("idle");

      // Normal bring-up: first edge sampling locked=1 is cycle 0
      locked = 1'b1;
      measure(22, 0, "bringup");
      check_rises("bringup", 10);

      // Software reset in RUN
      sw = 1'b1;
      tick("sw");
      sw = 1'b0;
      check("sw.stage_zero", 32'(stage), 32'd0);
      check("sw.done_zero",  32'(done),  32'd0);
      measure(20, 1, "sw_rel");
      check_rises("sw_rel", 8);
      check("sw.lost_unchanged", 32'(lost), 32'd0);

      // Lock loss in RUN: outputs drop at the third sampling edge
      locked = 1'b0;
      tick("loss1");
      tick("loss2");
      check("loss.stage_held", 32'(stage), 32'((1 << NS) - 1));
      tick("loss3");
      check("loss.stage_zero", 32'(stage), 32'd0);
      check("loss.done_zero",  32'(done),  32'd0);
      check("loss.lost_set",   32'(lost),  32'd1);
      tick("loss_wait");
      tick("loss_wait");
      locked = 1'b1;
      measure(22, 0, "relock");
      check_rises("relock", 10);
      check("relock.lost_sticky", 32'(lost), 32'd1);

      // Lock glitch during STABILIZE: no release, full restart
      rst_n = 1'b0;
      tick("rst2");
      rst_n = 1'b1;
      check("rst2.lost_clear", 32'(lost), 32'd0);
      tick("glitch_pre");
      tick("glitch_pre");
      tick("glitch_pre");
      tick("glitch_pre");
      locked = 1'b0;
      for (int i = 0; i < 3; i++) tick("glitch_low");
      locked = 1'b1;
      measure(6, 0, "glitch_gap");
      check("glitch.no_release", 32'(stage), 32'd0);
      measure(22, 6, "glitch_rel");
      check_rises("glitch", 10);

      // Simultaneous lock loss and software request in RUN
      locked = 1'b0;
      tick("simul");
      tick("simul");
      sw = 1'b1;
      tick("simul_edge");
      sw = 1'b0;
      check("simul.stage_zero", 32'(stage), 32'd0);
      check("simul.lost_set",   32'(lost),  32'd1);
      tick("simul_wait");
      tick("simul_wait");
      tick("simul_wait");
      check("simul.still_waiting", 32'(stage), 32'd0);

      // Reset after stage 0 released
      locked = 1'b1;
      measure(12, 0, "pre_rst");
      check("rstrel.stage0_out", 32'(stage), 32'd1);
      rst_n = 1'b0;
      tick("rstrel");
      check("rstrel.stage_zero", 32'(stage), 32'd0);
      check("rstrel.done_zero",  32'(done),  32'd0);
      check("rstrel.lost_zero",  32'(lost),  32'd0);
`ifdef RST_SEQ_LOCK_LOST_CNT_EN
      check("rstrel.lcnt_zero", 32'(lost_cnt), 32'd0);
`endif
      rst_n = 1'b1;

      // Randomized traffic
      low_left = 0;
      for (int i = 0; i < 4000; i++) begin
         if (low_left > 0) begin
            locked = 1'b0;
            low_left--;
         end else begin
            locked = 1'b1;
            if ($urandom_range(0, 59) == 0) low_left = $urandom_range(1, 6);
         end
         sw    = ($urandom_range(0, 24) == 0);
         rst_n = !($urandom_range(0, 399) == 0);
         tick("rand");
      end
      rst_n = 1'b1;
      sw    = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
